// File: rtl/kmeans_pkg.sv
// Shared constants, state encoding and channel slicing helpers for the K-means datapath.
package kmeans_pkg;

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned PIX_W  = NUM_CH * CH_W;
  localparam int unsigned SUM_W  = NUM_CH * ACC_W;
  localparam int unsigned REM_W  = CNT_W + 1;
  localparam int unsigned ITER_W = 5;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Channel 0 is red and sits in the most significant slice.
  function automatic int unsigned pix_lsb(input int unsigned ch);
    return (NUM_CH - 1 - ch) * CH_W;
  endfunction

  function automatic int unsigned sum_lsb(input int unsigned ch);
    return (NUM_CH - 1 - ch) * ACC_W;
  endfunction

  // Clamp a full-width quotient to one mean channel.
  function automatic logic [CH_W-1:0] saturate(input logic [ACC_W-1:0] q);
    return (|q[ACC_W-1:CH_W]) ? {CH_W{1'b1}} : q[CH_W-1:0];
  endfunction

endpackage

// File: rtl/channel_divider.sv
// Restoring divider: one quotient bit per step, MSB first, dividend shifted out of the quotient register.
module channel_divider
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [ACC_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [ACC_W-1:0] quotient,
  output logic [REM_W-1:0] remainder
);

  logic [CNT_W-1:0] dvs_q;
  logic [REM_W-1:0] shifted_c;
  logic [REM_W-1:0] diff_c;
  logic             ge_c;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted_c = {remainder[REM_W-2:0], quotient[ACC_W-1]};
    ge_c      = (shifted_c >= {1'b0, dvs_q});
    diff_c    = shifted_c - {1'b0, dvs_q};
  end

  // Load operands or advance one restoring step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dvs_q     <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs_q     <= divisor;
    end else if (step) begin
      quotient  <= {quotient[ACC_W-2:0], ge_c};
      remainder <= ge_c ? diff_c : shifted_c;
    end
  end

endmodule

// File: rtl/mean_update.sv
// Computes one cluster's new RGB mean from channel sums and pixel count, and flags movement.
module mean_update
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] accumulator,
  input  logic [CNT_W-1:0] counter,
  input  logic [PIX_W-1:0] old_mean,
  output logic             busy,
  output logic             done,
  output logic [PIX_W-1:0] new_mean,
  output logic             changed
);

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt_q;
  logic [PIX_W-1:0]  old_q;
  logic [ITER_W-1:0] iter;

  logic load_c;
  logic step_c;
  logic fin_c;

  logic [ACC_W-1:0] quo        [NUM_CH];
  logic [REM_W-1:0] rem_unused [NUM_CH];
  logic [PIX_W-1:0] mean_c;
  logic [PIX_W-1:0] result_c;

  // Three parallel channel dividers sharing load/step and the count as divisor.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    channel_divider u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (load_c),
      .step      (step_c),
      .dividend  (accumulator[sum_lsb(ch) +: ACC_W]),
      .divisor   (counter),
      .quotient  (quo[ch]),
      .remainder (rem_unused[ch])
    );
    assign mean_c[pix_lsb(ch) +: CH_W] = saturate(quo[ch]);
  end

  // An empty cluster keeps its old mean instead of dividing by zero.
  assign result_c = (cnt_q == '0) ? old_q : mean_c;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (counter == '0) ? FIN : DIV;
      DIV:     if (iter == LAST_ITER) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode per state.
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    fin_c  = 1'b0;
    case (state)
      IDLE:    load_c = start;
      DIV:     step_c = 1'b1;
      FIN:     fin_c  = 1'b1;
      default: ;
    endcase
  end

  // Operand latches, iteration counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      old_q    <= '0;
      iter     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      new_mean <= '0;
      changed  <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= fin_c;
      if (load_c) begin
        cnt_q <= counter;
        old_q <= old_mean;
        iter  <= '0;
      end else if (step_c) begin
        iter <= iter + ITER_W'(1);
      end
      if (fin_c) begin
        new_mean <= result_c;
        changed  <= (result_c != old_q);
      end
    end
  end

endmodule
